// File: rtl/io_port_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : io_port_bridge                                                |
// | Description : Host-side peer of the processor I/O pins. Bytes from the host |
// |               are queued in an input FIFO and presented on In_port. Each    |
// |               queued byte raises an interrupt request, and the byte is      |
// |               popped when the CPU acknowledges it. Bytes the CPU writes on  |
// |               Out_port are queued in an output FIFO for the host.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
// Parameters
//   DEPTH        entries per FIFO (power of two, >= 2)
//   INT_PULSE    cycles int_req is held high per request (1..15)
//   ACK_TIMEOUT  cycles waited for cpu_in_ack before re-raising int_req (2..255)
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   host_in_valid/data/ready      host -> input FIFO handshake
//   In_port                       head of input FIFO, 8'h00 when empty
//   int_req                       interrupt request to the processor (the int pin)
//   cpu_in_ack                    processor consumed In_port (1-cycle pulse)
//   Out_port, cpu_out_we          processor output byte and its strobe
//   host_out_valid/data/ready     output FIFO -> host handshake
//   ack_timeout                   sticky: an acknowledge timeout has occurred
//   out_overflow                  sticky: a CPU output byte was dropped
//   out_drop_cnt                  saturating count of dropped output bytes,
//                                 present only when IO_BRIDGE_DROP_CNT_EN is defined
// +----------------------------------------------------------------------------+

module io_port_bridge #(
  parameter int DEPTH       = 4,
  parameter int INT_PULSE   = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_in_valid,
  input  logic [7:0] host_in_data,
  output logic       host_in_ready,
  output logic [7:0] In_port,
  output logic       int_req,
  input  logic       cpu_in_ack,
  input  logic [7:0] Out_port,
  input  logic       cpu_out_we,
  output logic       host_out_valid,
  output logic [7:0] host_out_data,
  input  logic       host_out_ready,
  output logic       ack_timeout,
  output logic       out_overflow
`ifdef IO_BRIDGE_DROP_CNT_EN
  ,
  output logic [7:0] out_drop_cnt
`endif
);

  localparam int         AW           = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC     = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0] PULSE_LOAD   = 4'(INT_PULSE - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Input FIFO (host -> CPU)
  // --------------------------------------------------------------------------
  logic [7:0]  in_mem [DEPTH];
  logic [AW:0] in_wr_ptr;
  logic [AW:0] in_rd_ptr;
  logic        in_full;
  logic        in_empty;
  logic        in_push;
  logic        in_pop;

  assign in_empty = (in_wr_ptr == in_rd_ptr);
  assign in_full  = (in_wr_ptr[AW] != in_rd_ptr[AW]) &&
                    (in_wr_ptr[AW-1:0] == in_rd_ptr[AW-1:0]);

  // Readiness depends only on fullness: a same-cycle pop never frees a slot
  // for a push while full.
  assign host_in_ready = !rst && !in_full;
  assign in_push       = host_in_valid && host_in_ready;
  assign In_port       = (rst || in_empty) ? 8'h00 : in_mem[in_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (in_push) begin
      in_mem[in_wr_ptr[AW-1:0]] <= host_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
    end else begin
      if (in_push) begin
        in_wr_ptr <= in_wr_ptr + PTR_INC;
      end
      if (in_pop) begin
        in_rd_ptr <= in_rd_ptr + PTR_INC;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] pulse_cnt;
  logic [3:0] pulse_cnt_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pulse_cnt   <= '0;
      wait_cnt    <= '0;
      ack_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (timeout_hit) begin
        ack_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    wait_cnt_nxt  = wait_cnt;
    in_pop        = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      IDLE: begin
        // Acks arriving here are ignored; returning through IDLE guarantees
        // a gap between consecutive requests.
        if (!in_empty) begin
          state_nxt     = REQ;
          pulse_cnt_nxt = PULSE_LOAD;
        end
      end
      REQ: begin
        if (cpu_in_ack) begin
          in_pop       = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (pulse_cnt == 4'd0) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = '0;
        end else begin
          pulse_cnt_nxt = pulse_cnt - 4'd1;
        end
      end
      WAIT: begin
        if (cpu_in_ack) begin
          in_pop       = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          // Re-request without popping: the same byte stays on In_port.
          timeout_hit   = 1'b1;
          state_nxt     = REQ;
          pulse_cnt_nxt = PULSE_LOAD;
          wait_cnt_nxt  = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign int_req = (state == REQ);

  // --------------------------------------------------------------------------
  // Output FIFO (CPU -> host)
  // --------------------------------------------------------------------------
  logic [7:0]  out_mem [DEPTH];
  logic [AW:0] out_wr_ptr;
  logic [AW:0] out_rd_ptr;
  logic        out_full;
  logic        out_empty;
  logic        out_push;
  logic        out_pop;
  logic        out_drop;

  assign out_empty = (out_wr_ptr == out_rd_ptr);
  assign out_full  = (out_wr_ptr[AW] != out_rd_ptr[AW]) &&
                     (out_wr_ptr[AW-1:0] == out_rd_ptr[AW-1:0]);

  assign host_out_valid = !rst && !out_empty;
  assign host_out_data  = (rst || out_empty) ? 8'h00 : out_mem[out_rd_ptr[AW-1:0]];
  assign out_pop        = host_out_valid && host_out_ready;
  // A host pop in the same cycle frees the slot the CPU write needs.
  assign out_push       = !rst && cpu_out_we && (!out_full || out_pop);
  assign out_drop       = cpu_out_we && out_full && !out_pop;

  always_ff @(posedge clk) begin
    if (out_push) begin
      out_mem[out_wr_ptr[AW-1:0]] <= Out_port;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr_ptr   <= '0;
      out_rd_ptr   <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (out_push) begin
        out_wr_ptr <= out_wr_ptr + PTR_INC;
      end
      if (out_pop) begin
        out_rd_ptr <= out_rd_ptr + PTR_INC;
      end
      if (out_drop) begin
        out_overflow <= 1'b1;
      end
    end
  end

`ifdef IO_BRIDGE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_drop_cnt <= 8'h00;
    end else if (out_drop && (out_drop_cnt != 8'hFF)) begin
      out_drop_cnt <= out_drop_cnt + 8'd1;
    end
  end
`else
  // Without the counter, drops are reported only through out_overflow.
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_port_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_io_port_bridge                                             |
// | Description : Self-checking bench for io_port_bridge. Directed scenarios    |
// |               for reset, interrupt timing, FIFO limits and timeouts, then   |
// |               randomized traffic compared against queue-based models.       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+

module tb_io_port_bridge;

  localparam int DEPTH       = 4;
  localparam int INT_PULSE   = 1;
  localparam int ACK_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_in_valid;
  logic [7:0] host_in_data;
  logic       host_in_ready;
  logic [7:0] In_port;
  logic       int_req;
  logic       cpu_in_ack;
  logic [7:0] Out_port;
  logic       cpu_out_we;
  logic       host_out_valid;
  logic [7:0] host_out_data;
  logic       host_out_ready;
  logic       ack_timeout;
  logic       out_overflow;
`ifdef IO_BRIDGE_DROP_CNT_EN
  logic [7:0] out_drop_cnt;
`endif

  always #5 clk = ~clk;

  io_port_bridge #(
    .DEPTH      (DEPTH),
    .INT_PULSE  (INT_PULSE),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_in_valid (host_in_valid),
    .host_in_data  (host_in_data),
    .host_in_ready (host_in_ready),
    .In_port       (In_port),
    .int_req       (int_req),
    .cpu_in_ack    (cpu_in_ack),
    .Out_port      (Out_port),
    .cpu_out_we    (cpu_out_we),
    .host_out_valid(host_out_valid),
    .host_out_data (host_out_data),
    .host_out_ready(host_out_ready),
    .ack_timeout   (ack_timeout),
`ifdef IO_BRIDGE_DROP_CNT_EN
    .out_drop_cnt  (out_drop_cnt),
`endif
    .out_overflow  (out_overflow)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  logic prev_int = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and count rising edges of int_req.
  task automatic step();
    @(negedge clk);
    if (int_req === 1'b1 && prev_int === 1'b0) pulses++;
    prev_int = int_req;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes3 [4];
    int         p0;
    int         n;
    logic [7:0] inq [$];
    logic [7:0] outq [$];
    logic       pending;
    logic       ovf_m;
    int         drops_m;
    logic       in_push, in_pop, out_push, out_pop;

    bytes3[0] = 8'h11; bytes3[1] = 8'h22; bytes3[2] = 8'h33; bytes3[3] = 8'h44;

    rst = 1'b1; host_in_valid = 1'b0; host_in_data = 8'h00; cpu_in_ack = 1'b0;
    Out_port = 8'h00; cpu_out_we = 1'b0; host_out_ready = 1'b0;

    // ---- 1: reset held for two cycles with a push offered ----
    host_in_valid = 1'b1; host_in_data = 8'h77;
    step();
    check_eq("t1 ready in reset", host_in_ready, 1'b0);
    check_eq("t1 In_port in reset", In_port, 8'h00);
    check_eq("t1 int in reset", int_req, 1'b0);
    step();
    check_eq("t1 out_valid in reset", host_out_valid, 1'b0);
    check_eq("t1 flags in reset", {ack_timeout, out_overflow}, 2'b00);
    rst = 1'b0; host_in_valid = 1'b0;
    step();
    check_eq("t1 ready after reset", host_in_ready, 1'b1);
    check_eq("t1 In_port after reset", In_port, 8'h00);
    check_eq("t1 int after reset", int_req, 1'b0);

    // ---- 2: single byte, interrupt latency and width ----
    host_in_valid = 1'b1; host_in_data = 8'hA5;
    step();
    host_in_valid = 1'b0;
    check_eq("t2 In_port after push", In_port, 8'hA5);
    check_eq("t2 int before REQ", int_req, 1'b0);
    step();
    check_eq("t2 int high", int_req, 1'b1);
    step();
    check_eq("t2 int pulse ends", int_req, 1'b0);
    cpu_in_ack = 1'b1;
    step();
    cpu_in_ack = 1'b0;
    check_eq("t2 In_port after ack", In_port, 8'h00);
    check_eq("t2 ready after ack", host_in_ready, 1'b1);
    step();
    check_eq("t2 no further int", int_req, 1'b0);

    // ---- 3: fill input FIFO, refuse a fifth byte, drain in order ----
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      host_in_valid = 1'b1; host_in_data = bytes3[i];
      step();
    end
    host_in_valid = 1'b0;
    check_eq("t3 ready when full", host_in_ready, 1'b0);
    host_in_valid = 1'b1; host_in_data = 8'h55;
    step();
    host_in_valid = 1'b0;
    check_eq("t3 still full", host_in_ready, 1'b0);
    check_eq("t3 head after refused push", In_port, 8'h11);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while ((pulses - p0) <= i && n < 40) begin
        step();
        n++;
      end
      check_eq("t3 int pulse seen", ((pulses - p0) > i), 1'b1);
      check_eq("t3 byte order", In_port, bytes3[i]);
      cpu_in_ack = 1'b1;
      step();
      // Keep the ack high into the IDLE cycle that follows: it must be ignored.
      if (i == 0) step();
      cpu_in_ack = 1'b0;
      if (i == 0) check_eq("t3 ack in IDLE ignored", In_port, 8'h22);
    end
    step(); step(); step();
    check_eq("t3 pulse count", pulses - p0, 4);
    check_eq("t3 empty after drain", In_port, 8'h00);
    check_eq("t3 ready after drain", host_in_ready, 1'b1);
    check_eq("t3 no timeout yet", ack_timeout, 1'b0);

    // ---- 4: acknowledge timeout ----
    host_in_valid = 1'b1; host_in_data = 8'h5A;
    step();
    host_in_valid = 1'b0;
    n = 0;
    while (int_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check_eq("t4 int raised", int_req, 1'b1);
    step();
    check_eq("t4 in WAIT", int_req, 1'b0);
    n = 0;
    while (ack_timeout !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_eq("t4 timeout cycles", n, ACK_TIMEOUT);
    check_eq("t4 ack_timeout set", ack_timeout, 1'b1);
    check_eq("t4 int re-raised", int_req, 1'b1);
    check_eq("t4 In_port unchanged", In_port, 8'h5A);
    cpu_in_ack = 1'b1;
    step();
    cpu_in_ack = 1'b0;
    check_eq("t4 popped after ack", In_port, 8'h00);
    check_eq("t4 ack_timeout sticky", ack_timeout, 1'b1);

    // ---- 5: output overflow ----
    host_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cpu_out_we = 1'b1; Out_port = 8'(i);
      step();
      if (i == 1) check_eq("t5 out head", host_out_data, 8'h01);
      if (i == 4) check_eq("t5 no overflow when just full", out_overflow, 1'b0);
    end
    cpu_out_we = 1'b0;
    check_eq("t5 out_overflow set", out_overflow, 1'b1);
`ifdef IO_BRIDGE_DROP_CNT_EN
    check_eq("t5 drop count", out_drop_cnt, 8'd1);
`endif
    host_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("t5 drain valid", host_out_valid, 1'b1);
      check_eq("t5 drain data", host_out_data, 8'(i));
      step();
    end
    host_out_ready = 1'b0;
    check_eq("t5 empty after drain", host_out_valid, 1'b0);

    // ---- 6: full output FIFO with simultaneous write and pop ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_eq("t6 flags cleared", {ack_timeout, out_overflow}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cpu_out_we = 1'b1; Out_port = 8'hA0 + 8'(i);
      step();
    end
    cpu_out_we = 1'b1; Out_port = 8'hA4; host_out_ready = 1'b1;
    step();
    cpu_out_we = 1'b0;
    check_eq("t6 no overflow", out_overflow, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check_eq("t6 drain data", host_out_data, 8'hA0 + 8'(i));
      step();
    end
    host_out_ready = 1'b0;
    check_eq("t6 empty after drain", host_out_valid, 1'b0);

    // ---- randomized traffic against queue models ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    pending = 1'b0; ovf_m = 1'b0; drops_m = 0;
    inq.delete(); outq.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      check_eq("rnd in_ready", host_in_ready, (inq.size() < DEPTH));
      check_eq("rnd In_port", In_port, (inq.size() == 0) ? 8'h00 : inq[0]);
      check_eq("rnd out_valid", host_out_valid, (outq.size() != 0));
      check_eq("rnd out_data", host_out_data, (outq.size() == 0) ? 8'h00 : outq[0]);
      check_eq("rnd out_overflow", out_overflow, ovf_m);
`ifdef IO_BRIDGE_DROP_CNT_EN
      check_eq("rnd drop count", out_drop_cnt, 8'(drops_m));
`endif
      if (int_req === 1'b1) begin
        pending = 1'b1;
        check_eq("rnd int only with data", (inq.size() != 0), 1'b1);
      end

      host_in_valid  = ($urandom_range(0, 1) == 1);
      host_in_data   = 8'($urandom);
      cpu_in_ack     = pending && ($urandom_range(0, 3) == 0);
      if (cpu_in_ack) pending = 1'b0;
      cpu_out_we     = ($urandom_range(0, 1) == 1);
      Out_port       = 8'($urandom);
      host_out_ready = ($urandom_range(0, 2) == 0);

      in_push  = host_in_valid && (inq.size() < DEPTH);
      in_pop   = cpu_in_ack;
      out_pop  = host_out_ready && (outq.size() != 0);
      out_push = cpu_out_we && ((outq.size() < DEPTH) || out_pop);
      if (cpu_out_we && !out_push) begin
        ovf_m = 1'b1;
        if (drops_m < 255) drops_m++;
      end

      step();

      if (in_pop)   void'(inq.pop_front());
      if (in_push)  inq.push_back(host_in_data);
      if (out_pop)  void'(outq.pop_front());
      if (out_push) outq.push_back(Out_port);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
